// File: rtl/wm_pkg.sv
// Shared types for the washing-machine preset sequencer: phase encoding and preset field layout.
// Pure declarations; no logic, no latency, no flow control.
package wm_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_WASH  = 3'd1,
    PH_RINSE = 3'd2,
    PH_SPIN  = 3'd3,
    PH_DONE  = 3'd4
  } phase_e;

  localparam int NUM_FIELDS = 4;
  localparam int F_WASH     = 0;
  localparam int F_RINSE    = 1;
  localparam int F_SPIN     = 2;
  localparam int F_CLOTH    = 3;

endpackage

// File: rtl/wm_preset_sequencer_if.sv
// Preset bank access bus: slot select, write data and registered readback.
// Write lands on the sampling edge; readback is one cycle behind sel; no backpressure.
interface wm_preset_sequencer_if #(
  parameter int FIELD_W = 5,
  parameter int SEL_W   = 2
);
  logic                   wr_en;
  logic [SEL_W-1:0]       sel;
  logic [3:0][FIELD_W-1:0] wr_dat;
  logic [3:0][FIELD_W-1:0] rd_dat;

  modport master (output wr_en, sel, wr_dat, input  rd_dat);
  modport slave  (input  wr_en, sel, wr_dat, output rd_dat);
endinterface

// File: rtl/wm_preset_bank.sv
// Preset slot storage with write port, registered readback and an unregistered view of slot sel.
// Readback latency 1 cycle; writes always accepted, no backpressure.
module wm_preset_bank
  import wm_pkg::*;
#(
  parameter int FIELD_W     = 5,
  parameter int NUM_PRESETS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  wm_preset_sequencer_if.slave                 bus,
  output logic [NUM_FIELDS-1:0][FIELD_W-1:0]   cur_dat
);

  typedef logic [NUM_FIELDS-1:0][FIELD_W-1:0] slot_t;

  slot_t mem_q [NUM_PRESETS];
  slot_t mem_d [NUM_PRESETS];
  slot_t rd_q, rd_d;

  always_comb begin
    mem_d = mem_q;
    if (bus.wr_en) mem_d[bus.sel] = bus.wr_dat;
    rd_d = mem_q[bus.sel];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PRESETS; i++) mem_q[i] <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

  assign bus.rd_dat = rd_q;
  // Pre-write contents, so a start colliding with a write snapshots the old slot.
  assign cur_dat    = mem_q[bus.sel];

endmodule

// File: rtl/wm_preset_sequencer.sv
// Wash/rinse/spin run sequencer over a preset bank; phases last D*TICK_DIV+1 cycles, done/reject are 1-cycle pulses.
// No backpressure; optional pause input exists only when WM_PAUSE_EN is defined.
module wm_preset_sequencer
  import wm_pkg::*;
#(
  parameter int FIELD_W     = 5,
  parameter int NUM_PRESETS = 4,
  parameter int TICK_DIV    = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_PRESETS)-1:0] sel,
  input  logic [FIELD_W-1:0]             wash_in,
  input  logic [FIELD_W-1:0]             rinse_in,
  input  logic [FIELD_W-1:0]             spin_in,
  input  logic [FIELD_W-1:0]             cloth_in,
  output logic [FIELD_W-1:0]             rd_wash,
  output logic [FIELD_W-1:0]             rd_rinse,
  output logic [FIELD_W-1:0]             rd_spin,
  output logic [FIELD_W-1:0]             rd_cloth,
  input  logic                           start,
  input  logic                           abort,
`ifdef WM_PAUSE_EN
  input  logic                           pause,
`endif
  output logic                           busy,
  output logic [2:0]                     phase,
  output logic [FIELD_W-1:0]             remaining,
  output logic                           done,
  output logic                           reject
);

  localparam int SEL_W = $clog2(NUM_PRESETS);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic pause_i;
`ifdef WM_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  wm_preset_sequencer_if #(.FIELD_W(FIELD_W), .SEL_W(SEL_W)) bank_if ();

  logic [NUM_FIELDS-1:0][FIELD_W-1:0] cur_dat;

  assign bank_if.wr_en  = wr_en;
  assign bank_if.sel    = sel;
  assign bank_if.wr_dat = {cloth_in, spin_in, rinse_in, wash_in};

  wm_preset_bank #(.FIELD_W(FIELD_W), .NUM_PRESETS(NUM_PRESETS)) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bank_if.slave),
    .cur_dat (cur_dat)
  );

  phase_e                  state_q, state_d;
  logic [FIELD_W-1:0]      rem_q, rem_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [1:0][FIELD_W-1:0] snap_q, snap_d;
  logic                    done_q, done_d;
  logic                    reject_q, reject_d;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    div_d    = div_q;
    snap_d   = snap_q;
    done_d   = 1'b0;
    reject_d = 1'b0;
    unique case (state_q)
      PH_IDLE: begin
        if (start) begin
          if (cur_dat[F_CLOTH] != '0) begin
            state_d = PH_WASH;
            rem_d   = cur_dat[F_WASH];
            div_d   = '0;
            snap_d  = {cur_dat[F_SPIN], cur_dat[F_RINSE]};
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      PH_WASH, PH_RINSE, PH_SPIN: begin
        if (abort) begin
          state_d = PH_IDLE;
          rem_d   = '0;
          div_d   = '0;
        end else if (!pause_i) begin
          if (rem_q == '0) begin
            div_d = '0;
            if (state_q == PH_WASH) begin
              state_d = PH_RINSE;
              rem_d   = snap_q[0];
            end else if (state_q == PH_RINSE) begin
              state_d = PH_SPIN;
              rem_d   = snap_q[1];
            end else begin
              state_d = PH_DONE;
              done_d  = 1'b1;
            end
          end else if (div_q == DIV_W'(TICK_DIV - 1)) begin
            rem_d = rem_q - 1'b1;
            div_d = '0;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      PH_DONE: state_d = PH_IDLE;
      default: state_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PH_IDLE;
      rem_q    <= '0;
      div_q    <= '0;
      snap_q   <= '0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      snap_q   <= snap_d;
      done_q   <= done_d;
      reject_q <= reject_d;
    end
  end

  assign phase     = state_q;
  assign busy      = (state_q == PH_WASH) || (state_q == PH_RINSE) || (state_q == PH_SPIN);
  assign remaining = rem_q;
  assign done      = done_q;
  assign reject    = reject_q;
  assign rd_wash   = bank_if.rd_dat[F_WASH];
  assign rd_rinse  = bank_if.rd_dat[F_RINSE];
  assign rd_spin   = bank_if.rd_dat[F_SPIN];
  assign rd_cloth  = bank_if.rd_dat[F_CLOTH];

endmodule
